// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Issues sequential word addresses to a
// fixed-latency instruction BRAM, tracks every in-flight read, and buffers
// returned instructions in a small queue presented to decode over valid/ready.
// Issue is credit-based (in-flight reads + queued entries never exceed the
// queue depth), so a returning read always finds a free slot. A redirect
// kills all in-flight reads and empties the queue in one cycle.
module fetch_unit #(
    parameter int XLEN        = 32,
    parameter int MEM_LATENCY = 2,
    parameter int QUEUE_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           redirect_valid,
    input  logic [XLEN-1:0]                redirect_pc,
    output logic [XLEN-1:0]                pc_to_cache,
    output logic                           req_valid,
    input  logic [XLEN-1:0]                instr_from_cache,
    output logic [XLEN-1:0]                instr_to_decode,
    output logic [XLEN-1:0]                pc_to_decode,
    output logic                           valid,
    input  logic                           ready,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(QUEUE_DEPTH + 1);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int INF_W = $clog2(MEM_LATENCY + 1);

    logic [XLEN-1:0]  pc_reg;
    logic             live_reg [MEM_LATENCY];
    logic [XLEN-1:0]  tpc_reg  [MEM_LATENCY];
    logic [INF_W-1:0] inflight_reg;
    logic [XLEN-1:0]  qinstr_reg [QUEUE_DEPTH];
    logic [XLEN-1:0]  qpc_reg    [QUEUE_DEPTH];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [OCC_W-1:0] count_reg;

    logic [31:0] credit_used;
    logic        issue;
    logic        ret;
    logic        pop;
    logic        unused_pc_bits;

    // Low two bits of the redirect target are dropped (word-aligned fetch).
    assign unused_pc_bits = ^redirect_pc[1:0];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit check uses registered state only; a same-cycle pop frees nothing.
    assign credit_used = 32'(inflight_reg) + 32'(count_reg);
    assign issue       = !reset && !redirect_valid && (credit_used < 32'(QUEUE_DEPTH));
    assign ret         = live_reg[MEM_LATENCY-1];
    assign pop         = (count_reg != '0) && ready;

    assign pc_to_cache     = pc_reg;
    assign req_valid       = issue;
    assign valid           = (count_reg != '0);
    assign occupancy       = count_reg;
    assign instr_to_decode = qinstr_reg[head_reg];
    assign pc_to_decode    = qpc_reg[head_reg];

    // Fetch PC: reset, then redirect target, then advance by one word per issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg <= RESET_PC;
        end else if (redirect_valid) begin
            pc_reg <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (issue) begin
            pc_reg <= pc_reg + XLEN'(4);
        end
    end

    // Tracker stage 0: a live entry for an issued read, otherwise a bubble.
    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            live_reg[0] <= 1'b0;
            tpc_reg[0]  <= '0;
        end else begin
            live_reg[0] <= issue;
            tpc_reg[0]  <= pc_reg;
        end
    end

    generate
        for (genvar gi = 1; gi < MEM_LATENCY; gi++) begin : g_track
            // Tracker stage gi: shift; redirect kills every live bit.
            always_ff @(posedge clk) begin
                if (reset || redirect_valid) begin
                    live_reg[gi] <= 1'b0;
                    tpc_reg[gi]  <= '0;
                end else begin
                    live_reg[gi] <= live_reg[gi-1];
                    tpc_reg[gi]  <= tpc_reg[gi-1];
                end
            end
        end
    endgenerate

    // Count of reads issued but not yet returned.
    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            inflight_reg <= '0;
        end else begin
            case ({issue, ret})
                2'b10:   inflight_reg <= inflight_reg + INF_W'(1);
                2'b01:   inflight_reg <= inflight_reg - INF_W'(1);
                default: inflight_reg <= inflight_reg;
            endcase
        end
    end

    // Queue pointers and count; redirect empties the queue by snapping head to tail.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (redirect_valid) begin
            head_reg  <= tail_reg;
            count_reg <= '0;
        end else begin
            if (ret) tail_reg <= ptr_inc(tail_reg);
            if (pop) head_reg <= ptr_inc(head_reg);
            case ({ret, pop})
                2'b10:   count_reg <= count_reg + OCC_W'(1);
                2'b01:   count_reg <= count_reg - OCC_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_queue
            // Queue entry gi: written with returned data when it is the tail.
            always_ff @(posedge clk) begin
                if (reset) begin
                    qinstr_reg[gi] <= '0;
                    qpc_reg[gi]    <= '0;
                end else if (!redirect_valid && ret && (tail_reg == PTR_W'(gi))) begin
                    qinstr_reg[gi] <= instr_from_cache;
                    qpc_reg[gi]    <= tpc_reg[MEM_LATENCY-1];
                end
            end
        end
    endgenerate

endmodule
